// File: rtl/ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// ram_burst_ctrl
//
// Burst access controller that sits directly in front of a single-port
// synchronous RAM (AW address bits x DW data bits, 1-cycle read latency).
//
// A burst command (write or read, start address, length-1) is taken on a
// valid/ready handshake. The controller then drives the RAM strobes:
//   - write bursts stream wdata beats straight onto the RAM write port,
//   - read bursts issue RAM reads and return the data on a valid/ready stream
//     through a 2-entry response buffer. That buffer absorbs the RAM read
//     latency and any downstream backpressure.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_we/cmd_addr/cmd_len            1=write burst; start address; beats-1
//   wdata_valid/wdata_ready/wdata      write beat stream
//   rdata_valid/rdata_ready            read beat stream handshake
//   rdata/rdata_last                   read beat data; final beat of burst
//   err                                one-cycle pulse: burst rejected
//   cen/wen/s_addr/s_din               RAM chip enable, write enable,
//                                      address and write data
//   s_dout                             RAM read data (valid the cycle after
//                                      a read access)
//
// Optional feature (compile-time macro RAMC_BOUNDARY_ERR_EN):
//   When the macro is defined, a command whose burst would run past the top
//   of the address space is still accepted. It is then dropped without any
//   RAM access or data transfer, and err pulses for one cycle.
//   When the macro is undefined, err is tied low and such bursts wrap to
//   address 0.
// -----------------------------------------------------------------------------
module ram_burst_ctrl #(
    parameter int AW = 8,
    parameter int DW = 64,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    input  logic          rdata_ready,
    output logic [DW-1:0] rdata,
    output logic          rdata_last,
    output logic          err,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_din,
    input  logic [DW-1:0] s_dout
);

    // Beat counters need one extra bit so that they can reach len+1.
    localparam int CW = LW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;        // address of the next access
    logic [LW-1:0]   len_q, len_d;
    logic [CW-1:0]   beat_q, beat_d;        // write beats accepted
    logic [CW-1:0]   issued_q, issued_d;    // read accesses issued
    logic            infl_q, infl_d;        // read issued last cycle, data on s_dout now
    logic            infl_last_q, infl_last_d;
    logic [DW-1:0]   buf_data_q [0:1];
    logic [DW-1:0]   buf_data_d [0:1];
    logic            buf_last_q [0:1];
    logic            buf_last_d [0:1];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      occ_q, occ_d;          // buffer occupancy, 0..2
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic [DW-1:0]   last_din_q, last_din_d;

    logic            pop;
    logic [1:0]      outstanding;

`ifdef RAMC_BOUNDARY_ERR_EN
    logic            err_q, err_d;
    logic [AW:0]     end_addr;
    logic            cmd_bad;

    // A carry out of the end address means the burst crosses the top of memory.
    assign end_addr = {1'b0, cmd_addr} + {{(AW + 1 - LW){1'b0}}, cmd_len};
    assign cmd_bad  = end_addr[AW];
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdata_valid = (occ_q != 2'd0);
    assign rdata       = buf_data_q[rd_ptr_q];
    assign rdata_last  = rdata_valid && buf_last_q[rd_ptr_q];
    assign pop         = rdata_valid && rdata_ready;

    // Reads that will be in the buffer next cycle if we do not issue now.
    // Crediting this cycle's pop keeps one beat per cycle with rdata_ready
    // held high. Without a pop, no more than 2 reads are ever outstanding.
    assign outstanding = occ_q - {1'b0, pop} + {1'b0, infl_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        issued_d    = issued_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        cen         = 1'b0;
        wen         = 1'b0;
        s_addr      = last_addr_q;
        s_din       = last_din_q;
`ifdef RAMC_BOUNDARY_ERR_EN
        err_d       = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Gated by reset_n so that the handshake is held off while in reset.
                cmd_ready = reset_n;
                if (cmd_valid && reset_n) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    beat_d   = '0;
                    issued_d = '0;
`ifdef RAMC_BOUNDARY_ERR_EN
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = cmd_we ? S_WR : S_RD;
                    end
`else
                    state_d = cmd_we ? S_WR : S_RD;
`endif
                end
            end

            S_WR: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    cen    = 1'b1;
                    wen    = 1'b1;
                    s_addr = addr_q;
                    s_din  = wdata;
                    addr_d = addr_q + AW'(1);
                    beat_d = beat_q + CW'(1);
                    if (beat_q == {1'b0, len_q}) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_RD: begin
                if ((issued_q <= {1'b0, len_q}) && (outstanding < 2'd2)) begin
                    cen         = 1'b1;
                    s_addr      = addr_q;
                    addr_d      = addr_q + AW'(1);
                    issued_d    = issued_q + CW'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (issued_q == {1'b0, len_q});
                end
                if (pop && buf_last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Response buffer: push the RAM data one cycle after the read, and pop
        // on the consumer handshake. Both may happen in the same cycle.
        if (infl_q) begin
            buf_data_d[wr_ptr_q] = s_dout;
            buf_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};

        // RAM address/data hold their last driven value between accesses.
        last_addr_d = s_addr;
        last_din_d  = s_din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            issued_q      <= '0;
            infl_q        <= 1'b0;
            infl_last_q   <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            last_addr_q   <= '0;
            last_din_q    <= '0;
`ifdef RAMC_BOUNDARY_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            issued_q      <= issued_d;
            infl_q        <= infl_d;
            infl_last_q   <= infl_last_d;
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
            buf_last_q[0] <= buf_last_d[0];
            buf_last_q[1] <= buf_last_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            last_addr_q   <= last_addr_d;
            last_din_q    <= last_din_d;
`ifdef RAMC_BOUNDARY_ERR_EN
            err_q         <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_burst_ctrl
//
// Testbench for ram_burst_ctrl. It drives burst commands, models the attached
// 256 x 64 RAM, and checks the results with a scoreboard. Expected RAM writes
// and read beats are queued when each command is issued, taken from a shadow
// copy of memory. A negedge monitor pops the queues and compares them against
// what the controller presents. Inputs change 1 time unit after the rising
// edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_ram_burst_ctrl;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int LW = 4;

`ifdef RAMC_BOUNDARY_ERR_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          rdata_valid;
    logic          rdata_ready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic          err;
    logic          cen;
    logic          wen;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout = '0;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rdata_last(rdata_last), .err(err),
        .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
    );

    always #5 clk = ~clk;

    // The physical RAM behind the controller.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (cen) begin
            if (wen) ram[s_addr] <= s_din;
            else     s_dout <= ram[s_addr];
        end
    end

    // Reference model: memory contents as they should be after each command.
    logic [DW-1:0] shadow [0:255];

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [DW-1:0] d; logic l; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rd_mode  = 0;     // 0: ready always 1, 1: toggle, 2: random
    int issues   = 0;
    int pops     = 0;
    int max_out  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_summary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // rdata_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       rdata_ready = 1'b1;
                1:       rdata_ready = ~rdata_ready;
                default: rdata_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every RAM write and every read beat against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                issues = 0;
                pops   = 0;
            end else begin
                if (cen && wen) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        wr_t w;
                        w = wq.pop_front();
                        chk("write_addr", 64'(s_addr), 64'(w.a));
                        chk("write_data", s_din, w.d);
                    end
                end
                if (cen && !wen) issues++;
                if (rdata_valid && rdata_ready) begin
                    pops++;
                    if (rq.size() == 0) begin
                        chk("unexpected_rbeat", 1, 0);
                    end else begin
                        rd_t r;
                        r = rq.pop_front();
                        chk("rdata", rdata, r.d);
                        chk("rdata_last", 64'(rdata_last), 64'(r.l));
                    end
                end
                if (issues - pops > max_out) max_out = issues - pops;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},   64'(cmd_ready),   0);
        chk({tag, "_wdata_ready"}, 64'(wdata_ready), 0);
        chk({tag, "_rdata_valid"}, 64'(rdata_valid), 0);
        chk({tag, "_rdata"},       rdata,            0);
        chk({tag, "_rdata_last"},  64'(rdata_last),  0);
        chk({tag, "_err"},         64'(err),         0);
        chk({tag, "_cen"},         64'(cen),         0);
        chk({tag, "_wen"},         64'(wen),         0);
        chk({tag, "_s_addr"},      64'(s_addr),      0);
        chk({tag, "_s_din"},       s_din,            0);
    endtask

    // Present a command and return 1 time unit after the handshake edge.
    task automatic handshake(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            do_summary();
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Issue one burst, queue its expected effects, and drive it to completion.
    // pat: write data 0xA0+i; gap_fix: idle cycles between write beats;
    // gap_rnd: random gaps instead.
    task automatic burst(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int rmode, input bit pat, input int gap_fix, input bit gap_rnd);
        logic [DW-1:0] d [0:15];
        logic [AW-1:0] a;
        bit bad;
        int n;
        n   = int'(len) + 1;
        bad = BOUND_EN && (int'(addr) + int'(len) > 255);
        for (int i = 0; i < n; i++) begin
            a    = addr + AW'(i);
            d[i] = pat ? 64'hA0 + 64'(i) : {$urandom, $urandom};
            if (!bad) begin
                if (we) begin
                    wq.push_back('{a: a, d: d[i]});
                    shadow[a] = d[i];
                end else begin
                    rq.push_back('{d: shadow[a], l: (i == n - 1)});
                end
            end
        end
        rd_mode = rmode;
        handshake(we, addr, len);
        if (bad) begin
            @(negedge clk);
            chk("err_pulse", 64'(err), 1);
            chk("err_cen", 64'(cen), 0);
            @(negedge clk);
            chk("err_clear", 64'(err), 0);
            chk("err_cen2", 64'(cen), 0);
        end else if (we) begin
            for (int i = 0; i < n; i++) begin
                int g;
                g = gap_rnd ? $urandom_range(0, 2) : ((i == 0) ? 0 : gap_fix);
                repeat (g) begin
                    wdata_valid = 1'b0;
                    @(negedge clk);
                    chk("gap_cen", 64'(cen), 0);
                    @(posedge clk);
                    #1;
                end
                wdata_valid = 1'b1;
                wdata       = d[i];
                @(negedge clk);
                chk("wdata_ready", 64'(wdata_ready), 1);
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b0;
            @(negedge clk);
            chk("wr_done_cmd_ready", 64'(cmd_ready), 1);
        end else if (rmode == 0) begin
            // Beats are valid in cycles 3..len+3 after the handshake; IDLE after.
            for (int k = 1; k <= n + 3; k++) begin
                @(negedge clk);
                if (k <= n + 2) chk("rd_valid_timing", 64'(rdata_valid), 64'((k >= 3) && (k <= n + 2)));
                else            chk("rd_done_cmd_ready", 64'(cmd_ready), 1);
            end
        end else begin
            int t;
            t = 0;
            while (rq.size() != 0 && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("read_drain_left", 64'(rq.size()), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed cases
        burst(1'b1, 8'h10, 4'd3, 0, 1'b1, 0, 1'b0);
        burst(1'b0, 8'h10, 4'd3, 0, 1'b0, 0, 1'b0);
        burst(1'b0, 8'h10, 4'd3, 1, 1'b0, 0, 1'b0);
        burst(1'b1, 8'hFE, 4'd2, 0, 1'b0, 0, 1'b0);
        burst(1'b0, 8'hFE, 4'd2, 0, 1'b0, 0, 1'b0);
        burst(1'b1, 8'h40, 4'd3, 0, 1'b0, 3, 1'b0);
        burst(1'b0, 8'h40, 4'd3, 2, 1'b0, 0, 1'b0);

        // Reset during the 2nd beat of a len=7 read
        burst(1'b1, 8'h20, 4'd7, 0, 1'b0, 0, 1'b0);
        rd_mode = 0;
        for (int i = 0; i < 8; i++) rq.push_back('{d: shadow[8'h20 + i], l: (i == 7)});
        handshake(1'b0, 8'h20, 4'd7);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rq.delete();
        wq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        burst(1'b0, 8'h25, 4'd0, 0, 1'b0, 0, 1'b0);

        // Randomized bursts
        for (int c = 0; c < 40; c++) begin
            burst(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), 1'b0, 0, 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("write_queue_empty", 64'(wq.size()), 0);
        chk("max_outstanding_le2", 64'(max_out > 2), 0);
        do_summary();
    end

endmodule
